// File: rtl/display_arbiter.sv
// Round-robin owner of a shared 4-digit 7-segment display, with a minimum hold per grant.
// Optional macro DISP_ARB_BLANK_EN: drive BLANK_VAL on X and raise blank while idle.
module display_arbiter #(
    parameter int          N_REQ      = 4,
    parameter int          DIV        = 2500000,
    parameter int          HOLD_TICKS = 8,
    parameter logic [15:0] BLANK_VAL  = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  data,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     ack,
    output logic [15:0]          X,
    output logic                 busy,
    output logic                 blank
);

    localparam int IW = $clog2(N_REQ);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
`ifdef DISP_ARB_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif
    localparam logic [15:0]      RST_X = BLANK_EN ? BLANK_VAL : 16'h0000;
    localparam logic [N_REQ-1:0] ONE   = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [HW-1:0]   hold_cnt;
    logic [IW-1:0]   ptr;
    logic            tick;
    logic            expire;
    logic [IW-1:0]   nxt;
    logic [15:0]     nxt_x;
    logic [15:0]     cur_x;

    // First requester found scanning upward from p+1, wrapping; p itself is checked last.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] w;
        logic          found;
        int            idx;
        w     = p;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(p) + k) % N_REQ;
            if (!found && r[idx]) begin
                w     = IW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign tick   = (presc == PW'(DIV - 1));
    assign expire = tick && (hold_cnt == HW'(HOLD_TICKS - 1));
    assign nxt    = rr_pick(req, ptr);
    assign nxt_x  = data[16*int'(nxt) +: 16];
    assign cur_x  = data[16*int'(ptr) +: 16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // While holding, ptr is the current owner, so rr_pick(req, ptr) prefers any other requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            gnt      <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            X        <= RST_X;
            hold_cnt <= '0;
            ptr      <= IW'(N_REQ - 1);
`ifdef DISP_ARB_BLANK_EN
            blank    <= 1'b1;
`endif
        end else begin
            ack <= '0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        X        <= nxt_x;
                        gnt      <= ONE << nxt;
                        ack      <= ONE << nxt;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                        ptr      <= nxt;
                        state    <= S_HOLD;
`ifdef DISP_ARB_BLANK_EN
                        blank    <= 1'b0;
`endif
                    end
                end
                S_HOLD: begin
                    if (expire) begin
                        if (|(req & ~gnt)) begin
                            X        <= nxt_x;
                            gnt      <= ONE << nxt;
                            ack      <= ONE << nxt;
                            hold_cnt <= '0;
                            ptr      <= nxt;
                        end else if (req[ptr]) begin
                            hold_cnt <= '0;
                            X        <= cur_x;
                        end else begin
                            state <= S_IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                            if (BLANK_EN) X <= BLANK_VAL;
`ifdef DISP_ARB_BLANK_EN
                            blank <= 1'b1;
`endif
                        end
                    end else begin
                        if (tick) hold_cnt <= hold_cnt + HW'(1);
                        if (req[ptr]) X <= cur_x;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef DISP_ARB_BLANK_EN
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: directed scenarios plus random requests against a cycle model.
module tb_display_arbiter;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int HT  = 2;
`ifdef DISP_ARB_BLANK_EN
    localparam bit BLK = 1'b1;
`else
    localparam bit BLK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [16*N-1:0] data;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic [15:0]     X;
    logic            busy;
    logic            blank;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: owner index (-1 = idle), ticks seen in this hold, prescaler phase.
    int           m_owner;
    int           m_ptr;
    int           m_ticks;
    int           m_presc;
    logic [15:0]  m_x;
    logic [N-1:0] m_ack;

    display_arbiter #(.N_REQ(N), .DIV(DIV), .HOLD_TICKS(HT), .BLANK_VAL(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data),
        .gnt(gnt), .ack(ack), .X(X), .busy(busy), .blank(blank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return p;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_ticks = 0;
        m_presc = 0;
        m_x     = BLK ? 16'hFFFF : 16'h0000;
        m_ack   = '0;
    endtask

    task automatic model_grant(input int w);
        m_owner = w;
        m_ptr   = w;
        m_ticks = 0;
        m_x     = data[16*w +: 16];
        m_ack   = N'(1) << w;
    endtask

    task automatic model_edge();
        bit tk;
        tk    = (m_presc == DIV - 1);
        m_ack = '0;
        if (m_owner < 0) begin
            if (req != 0) model_grant(pick(req, m_ptr));
        end else if (tk && m_ticks == HT - 1) begin
            if ((req & ~(N'(1) << m_owner)) != 0) model_grant(pick(req, m_owner));
            else if (req[m_owner]) begin
                m_ticks = 0;
                m_x     = data[16*m_owner +: 16];
            end else begin
                m_owner = -1;
                if (BLK) m_x = 16'hFFFF;
            end
        end else begin
            if (tk) m_ticks++;
            if (req[m_owner]) m_x = data[16*m_owner +: 16];
        end
        m_presc = (m_presc + 1) % DIV;
    endtask

    task automatic compare_all();
        chk("gnt",   gnt,   (m_owner < 0) ? '0 : (N'(1) << m_owner));
        chk("ack",   ack,   m_ack);
        chk("X",     X,     m_x);
        chk("busy",  busy,  m_owner >= 0);
        chk("blank", blank, BLK && (m_owner < 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Asserts reset away from the clock edge and checks outputs before any edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_gnt",   gnt,   '0);
        chk("rst_ack",   ack,   '0);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_X",     X,     BLK ? 16'hFFFF : 16'h0000);
        chk("rst_blank", blank, BLK);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Steps until the grant drops; k is the number of cycles the grant survived.
    task automatic wait_idle(output int k);
        k = 0;
        while (gnt != 0 && k < 40) begin
            step();
            k++;
        end
        if (k >= 40) chk("idle_timeout", 32'(k), 32'(0));
    endtask

    initial begin
        int k;
        int acks;
        req  = '0;
        data = '0;
        rst  = 1'b0;
        #2;
        do_reset();

        // 1: single request gets the display one edge later
        data[15:0] = 16'h1234;
        req = 4'b0001;
        step();
        chk("t1_X", X, 16'h1234);
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_ack", ack, 4'b0001);
        chk("t1_busy", busy, 1'b1);
        step();
        chk("t1_ack_once", ack, 4'b0000);
        req = '0;
        wait_idle(k);

        // 2: two requesters alternate at each expiry
        do_reset();
        data[31:16] = 16'hABCD;
        req = 4'b0011;
        step();
        chk("t2_first", gnt, 4'b0001);
        k = 0;
        while (gnt == 4'b0001 && k < 20) begin step(); k++; end
        chk("t2_gnt1", gnt, 4'b0010);
        chk("t2_X1", X, 16'hABCD);
        chk("t2_ack1", ack, 4'b0010);
        k = 0;
        while (gnt == 4'b0010 && k < 20) begin step(); k++; end
        chk("t2_gnt0", gnt, 4'b0001);
        req = '0;
        wait_idle(k);

        // 3: one-cycle request still receives a full hold, then idle
        do_reset();
        req = 4'b0001;
        step();
        req = '0;
        wait_idle(k);
        chk("t3_hold_len", 32'(k >= 5 && k <= 8), 32'd1);
        chk("t3_X", X, BLK ? 16'hFFFF : 16'h1234);
        chk("t3_blank", blank, BLK);
        chk("t3_busy", busy, 1'b0);

        // 4: live data update while held
        do_reset();
        req = 4'b0001;
        step();
        step();
        data[15:0] = 16'h5678;
        step();
        chk("t4_X", X, 16'h5678);
        chk("t4_ack", ack, 4'b0000);
        chk("t4_gnt", gnt, 4'b0001);

        // 5: reset mid-hold, then restart from a fresh state
        req = '0;
        #2;
        do_reset();
        data[63:48] = 16'h9ABC;
        req = 4'b1000;
        step();
        chk("t5_gnt", gnt, 4'b1000);
        req = '0;
        wait_idle(k);
        chk("t5_hold_len", 32'(k >= 5 && k <= 8), 32'd1);

        // 6: lone holder keeps the grant across expiries with one ack
        do_reset();
        data[15:0] = 16'h1234;
        req = 4'b0001;
        acks = 0;
        for (int i = 0; i < 3 * HT * DIV + 3; i++) begin
            step();
            if (ack[0]) acks++;
        end
        chk("t6_acks", 32'(acks), 32'd1);
        chk("t6_gnt", gnt, 4'b0001);
        req = '0;
        wait_idle(k);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            if ($urandom_range(3) == 0) data[16*$urandom_range(N-1) +: 16] = 16'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
